// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Keeps the program counter, issues at most one
// outstanding read to instruction memory, and presents each returned
// instruction with its PC in a one-entry output register. Redirects (branch or
// jump) replace the PC immediately. A response for a request made before the
// redirect is dropped, either in the cycle it arrives or in the S_DRAIN state.
//
// Optional feature:
//   FETCH_UNIT_PERF_CNT_EN - when defined, adds a 32-bit fetch_count output.
//                            It counts out_valid && out_ready handshakes.
//
// Ports:
//   clk              in   sole clock, rising edge
//   rst              in   synchronous active-high reset
//   redirect_valid   in   branch/jump redirect request
//   redirect_pc      in   redirect target, used as-is
//   imem_req_valid   out  instruction-memory read request
//   imem_req_addr    out  request address (always the current PC)
//   imem_req_ready   in   memory accepts the request
//   imem_resp_valid  in   read data valid
//   imem_resp_instr  in   read data
//   out_valid        out  pc_out/instr_out hold a fetched instruction
//   out_ready        in   downstream accepts the instruction
//   pc_out           out  PC of the presented instruction
//   instr_out        out  presented instruction
//   fetch_count      out  handshake counter (only with FETCH_UNIT_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out
`ifdef FETCH_UNIT_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic                   out_valid_next;
    logic [ADDR_WIDTH-1:0]  pc_out_next;
    logic [INSTR_WIDTH-1:0] instr_out_next;

    logic out_free;
    logic req_fire;

    // A new request may go out only when the output register will have room
    // for its result: it is empty now, or it is being consumed this cycle.
    assign out_free       = !out_valid || out_ready;
    assign imem_req_valid = (state == S_REQ) && out_free && !rst;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            pc_out    <= '0;
            instr_out <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            out_valid <= out_valid_next;
            pc_out    <= pc_out_next;
            instr_out <= instr_out_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        // The presented instruction leaves on a handshake; otherwise it is held.
        out_valid_next = out_valid && !out_ready;
        pc_out_next    = pc_out;
        instr_out_next = instr_out;

        if (redirect_valid) begin
            // A redirect wins over everything else. Any request still in
            // flight after this edge belongs to the old path. S_DRAIN swallows
            // its response when it arrives.
            pc_next        = redirect_pc;
            out_valid_next = 1'b0;
            case (state)
                S_REQ:   state_next = req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state_next = imem_resp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_next = S_DRAIN;
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        pc_out_next    = pc;
                        instr_out_next = imem_resp_instr;
                        out_valid_next = 1'b1;
                        pc_next        = pc + ADDR_WIDTH'(4);
                        state_next     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

`ifdef FETCH_UNIT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (out_valid && out_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Randomised bench for fetch_unit with a scoreboard. The stimulus process
// drives the inputs and also plays instruction memory. The memory answers
// each request after 1..3 cycles, and sometimes sends stray responses while
// no request is in flight. A reference model follows the fetch rules at the
// level of requests and PCs. It checks each request and pushes every
// instruction that should be delivered into a queue. An independent monitor
// pops that queue whenever the DUT presents or drops an output.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int             AW  = 12;
    localparam int             IW  = 32;
    localparam logic [AW-1:0]  RPC = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_instr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] pc_out;
    logic [IW-1:0] instr_out;
`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0]   fetch_count;
`endif

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .RESET_PC   (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_instr(imem_resp_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pc_out         (pc_out),
        .instr_out      (instr_out)
`ifdef FETCH_UNIT_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t exp_q[$];

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    bit freerun     = 1'b0;
    int freerun_hs  = 0;
    int total_hs    = 0;
    bit seen_rst    = 1'b0;

    // Memory side state, owned by the stimulus process.
    bit            mem_busy   = 1'b0;
    int            mem_count  = 0;
    logic [AW-1:0] mem_addr   = '0;
    bit            stale_stim = 1'b0;
    bit            orphan     = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory contents: a fixed scramble of the address, so every word differs.
    function automatic logic [IW-1:0] instr_for(input logic [AW-1:0] a);
        return {a, 20'h0} ^ (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // One cycle of stimulus. Inputs change on the falling edge. After the
    // inputs settle, any request the DUT issues is recorded and scheduled for
    // a response.
    task automatic applyStimulus(input int rdir_pct, input int rdy_pct,
                                 input int ordy_pct, input int dly_max,
                                 input int rst_pct, input bit force_rdir,
                                 input logic [AW-1:0] force_pc, input bit do_rst);
        bit resp_this;
        bit was_stale;
        bit issue;
        @(negedge clk);
        was_stale       = stale_stim;
        resp_this       = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_instr = $urandom;
        if (mem_busy) begin
            mem_count--;
            if (mem_count == 0) begin
                resp_this       = 1'b1;
                mem_busy        = 1'b0;
                imem_resp_valid = 1'b1;
                imem_resp_instr = instr_for(mem_addr);
            end
        end else if (orphan || int'($urandom_range(99)) < 10) begin
            imem_resp_valid = 1'b1;
            imem_resp_instr = $urandom;
            orphan          = 1'b0;
        end
        rst            = do_rst || (int'($urandom_range(99)) < rst_pct);
        redirect_valid = force_rdir || (int'($urandom_range(99)) < rdir_pct);
        redirect_pc    = force_rdir ? force_pc : AW'($urandom);
        // The response that finishes a drain never shares its cycle with a
        // redirect.
        if (resp_this && was_stale) redirect_valid = 1'b0;
        imem_req_ready = int'($urandom_range(99)) < rdy_pct;
        out_ready      = int'($urandom_range(99)) < ordy_pct;
        #1;
        issue = imem_req_valid && imem_req_ready;
        if (rst) begin
            // A request cut off by reset still answers one cycle later.
            if (mem_busy) orphan = 1'b1;
            mem_busy   = 1'b0;
            stale_stim = 1'b0;
        end else begin
            if (resp_this) stale_stim = 1'b0;
            if (issue) begin
                mem_busy  = 1'b1;
                mem_count = int'($urandom_range(dly_max, 1));
                mem_addr  = imem_req_addr;
            end
            if (redirect_valid && mem_busy) stale_stim = 1'b1;
        end
    endtask

    // Reference model. Sampled late in the cycle, after the monitor. It tracks
    // the fetch PC, whether a request is in flight, whether that request is
    // stale, and whether the output slot is full. It predicts the request
    // signals and queues every instruction that must reach the output.
    always begin : model_proc
        logic [AW-1:0] m_pc;
        bit m_out, m_busy, m_stale, exp_rv, issue, resp;
        @(negedge clk);
        #3;
        if (rst) begin
            seen_rst = 1'b1;
            checkOutput("req_valid_in_reset", 64'(imem_req_valid), 64'(0));
            m_pc    = RPC;
            m_out   = 1'b0;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            exp_q.delete();
        end else if (seen_rst) begin
            exp_rv = !m_busy && (!m_out || out_ready);
            checkOutput("imem_req_valid", 64'(imem_req_valid), 64'(exp_rv));
            if (imem_req_valid) checkOutput("imem_req_addr", 64'(imem_req_addr), 64'(m_pc));
            issue = imem_req_valid && imem_req_ready;
            resp  = imem_resp_valid && m_busy;
            if (out_ready) m_out = 1'b0;
            if (redirect_valid) begin
                m_pc  = redirect_pc;
                m_out = 1'b0;
                if (resp) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end
                if (issue) m_busy = 1'b1;
                if (m_busy) m_stale = 1'b1;
            end else begin
                if (resp) begin
                    m_busy = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        exp_q.push_back(exp_t'{pc: m_pc, instr: imem_resp_instr});
                        m_pc  = m_pc + AW'(4);
                        m_out = 1'b1;
                    end
                end
                if (issue) m_busy = 1'b1;
            end
        end
    end

    // Monitor. Compares the presented output against the queue. An entry
    // leaves the queue on a handshake or when a redirect drops it. While the
    // output is stalled, the head of the queue must stay on the ports.
    always begin : monitor_proc
        exp_t e;
        bit   prev_rst;
        int   last_hs;
        int   exp_count;
        @(negedge clk);
        #2;
        if (rst) begin
            prev_rst  = 1'b1;
            last_hs   = -1;
            exp_count = 0;
        end else if (seen_rst) begin
            if (prev_rst) begin
                checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
                checkOutput("reset_pc_out", 64'(pc_out), 64'(0));
                checkOutput("reset_instr_out", 64'(instr_out), 64'(0));
                checkOutput("reset_req_addr", 64'(imem_req_addr), 64'(RPC));
                prev_rst = 1'b0;
            end
`ifdef FETCH_UNIT_PERF_CNT_EN
            checkOutput("fetch_count", 64'(fetch_count), 64'(exp_count));
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else if (out_ready || redirect_valid) begin
                    e = exp_q.pop_front();
                    checkOutput("pc_out", 64'(pc_out), 64'(e.pc));
                    checkOutput("instr_out", 64'(instr_out), 64'(e.instr));
                end else begin
                    e = exp_q[0];
                    checkOutput("held_pc_out", 64'(pc_out), 64'(e.pc));
                    checkOutput("held_instr_out", 64'(instr_out), 64'(e.instr));
                end
            end
            if (out_valid && out_ready) begin
                exp_count++;
                total_hs++;
                if (freerun) begin
                    if (last_hs >= 0) checkOutput("freerun_gap", 64'(cycle - last_hs), 64'(2));
                    freerun_hs++;
                end
                last_hs = cycle;
            end
        end
    end

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_instr = '0;
        out_ready       = 1'b0;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1'b0, '0, 1'b1);

        // Ideal memory and consumer: one instruction every two cycles from PC 0.
        $display("[TB] free-running fetch");
        freerun = 1'b1;
        for (int i = 0; i < 14; i++) applyStimulus(0, 100, 100, 1, 0, 1'b0, '0, 1'b0);
        #3;
        checkOutput("freerun_handshakes", 64'(freerun_hs >= 5), 64'(1));
        freerun = 1'b0;

        // Stalled consumer: the output must hold and no new request may issue.
        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) applyStimulus(0, 100, 100, 1, 0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 100, 0, 1, 0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 100, 100, 1, 0, 1'b0, '0, 1'b0);

        // Redirect to 0x200 with slow memory, so it tends to land in the wait.
        $display("[TB] redirect during wait");
        for (int i = 0; i < 2; i++) applyStimulus(0, 100, 100, 3, 0, 1'b0, '0, 1'b0);
        applyStimulus(0, 100, 100, 3, 0, 1'b1, 12'h200, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 100, 100, 3, 0, 1'b0, '0, 1'b0);

        // Address wrap: 0xFFC must be followed by 0x000.
        $display("[TB] pc wrap");
        applyStimulus(0, 100, 100, 1, 0, 1'b1, 12'hFFC, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 100, 100, 1, 0, 1'b0, '0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) applyStimulus(8, 70, 60, 3, 1, 1'b0, '0, 1'b0);

        // Stop issuing, let the last request finish, and drain the output.
        $display("[TB] drain");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 100, 1, 0, 1'b0, '0, 1'b0);
        #3;
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        checkOutput("made_progress", 64'(total_hs > 100), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
